// File: rtl/get_lsp_pol.sv
// rtl/get_lsp_pol.sv - sequential LSP-to-polynomial stage feeding an external mpy_32_16
module get_lsp_pol #(
    parameter int ADDR_W   = 12,
    parameter int LSP_BASE = 0,
    parameter int F_BASE   = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              odd_sel_i,
    input  logic [31:0]       mem_in_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_out_o,
    output logic [31:0]       mpy_var1_o,
    output logic [15:0]       mpy_var2_o,
    input  logic [31:0]       mpy_in_i,
    output logic              overflow_o,
    output logic              done_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_LOOP = 3'd3;
    localparam logic [2:0] S_MSU  = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [2:0]  k_q, k_d, m_q, m_d, n_q, n_d;
    logic        odd_q, odd_d, ovf_q, ovf_d;
    logic [15:0] lsp_q, lsp_d;
    logic [31:0] f_q [0:5];
    logic [31:0] f_d [0:5];
    logic [32:0] r1, r2, r3;

    // Results carry the saturation flag in bit 32.
    function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) return {1'b1, s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF};
        return {1'b0, s[31:0]};
    endfunction

    function automatic logic [32:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} - {b[31], b};
        if (s[32] != s[31]) return {1'b1, s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF};
        return {1'b0, s[31:0]};
    endfunction

    function automatic logic [32:0] sat_shl1(input logic [31:0] x);
        if (x[31] != x[30]) return {1'b1, x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF};
        return {1'b0, x[30:0], 1'b0};
    endfunction

    function automatic logic [31:0] lsp_x1024(input logic [15:0] l);
        return {{6{l[15]}}, l, 10'b0};
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        m_d     = m_q;
        n_d     = n_q;
        odd_d   = odd_q;
        lsp_d   = lsp_q;
        ovf_d   = ovf_q;
        f_d     = f_q;
        r1      = '0;
        r2      = '0;
        r3      = '0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_RD;
                k_d     = 3'd0;
                ovf_d   = 1'b0;
                odd_d   = odd_sel_i;
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                lsp_d = mem_in_i[15:0];
                if (k_q == 3'd0) begin
                    r1      = sat_sub(32'h0, lsp_x1024(mem_in_i[15:0]));
                    f_d[0]  = 32'h0100_0000;
                    f_d[1]  = r1[31:0];
                    ovf_d   = ovf_q | r1[32];
                    k_d     = 3'd1;
                    state_d = S_RD;
                end else begin
                    f_d[k_q + 3'd1] = f_q[k_q - 3'd1];
                    m_d             = k_q + 3'd1;
                    state_d         = S_LOOP;
                end
            end
            S_LOOP: begin
                r1         = sat_add(f_q[m_q], f_q[m_q - 3'd2]);
                r2         = sat_shl1(mpy_in_i);
                r3         = sat_sub(r1[31:0], r2[31:0]);
                f_d[m_q]   = r3[31:0];
                ovf_d      = ovf_q | r1[32] | r2[32] | r3[32];
                m_d        = m_q - 3'd1;
                if (m_q == 3'd2) state_d = S_MSU;
            end
            S_MSU: begin
                r1     = sat_sub(f_q[1], lsp_x1024(lsp_q));
                f_d[1] = r1[31:0];
                ovf_d  = ovf_q | r1[32];
                if (k_q < 3'd4) begin
                    k_d     = k_q + 3'd1;
                    state_d = S_RD;
                end else begin
                    n_d     = 3'd0;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                n_d = n_q + 3'd1;
                if (n_q == 3'd5) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    always_comb begin
        mem_addr_o  = '0;
        mem_write_o = 1'b0;
        mem_out_o   = '0;
        mpy_var1_o  = '0;
        mpy_var2_o  = '0;
        done_o      = 1'b0;
        case (state_q)
            S_RD: mem_addr_o = ADDR_W'(LSP_BASE) + ADDR_W'({k_q, odd_q});
            S_LOOP: begin
                mpy_var1_o = {f_q[m_q - 3'd1][31:16], 1'b0, f_q[m_q - 3'd1][15:1]};
                mpy_var2_o = lsp_q;
            end
            S_WR: begin
                mem_addr_o  = ADDR_W'(F_BASE) + ADDR_W'(n_q);
                mem_write_o = 1'b1;
                mem_out_o   = f_q[n_q];
            end
            S_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    assign overflow_o = ovf_q;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            odd_q   <= 1'b0;
            ovf_q   <= 1'b0;
            lsp_q   <= '0;
            for (int i = 0; i < 6; i++) f_q[i] <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            m_q     <= m_d;
            n_q     <= n_d;
            odd_q   <= odd_d;
            ovf_q   <= ovf_d;
            lsp_q   <= lsp_d;
            f_q     <= f_d;
        end
    end

endmodule

// File: tb/tb_get_lsp_pol.sv
// tb/tb_get_lsp_pol.sv - scoreboard bench for get_lsp_pol against a G.729 reference model
`timescale 1ns/1ps
module tb_get_lsp_pol;

    localparam int ADDR_W = 12;
    localparam int F_BASE = 16;

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b0;
    logic              start_i = 1'b0;
    logic              odd_sel_i = 1'b0;
    logic [31:0]       mem_in_i = '0;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_write_o;
    logic [31:0]       mem_out_o;
    logic [31:0]       mpy_var1_o;
    logic [15:0]       mpy_var2_o;
    logic [31:0]       mpy_in_i;
    logic              overflow_o;
    logic              done_o;

    get_lsp_pol #(.ADDR_W(ADDR_W), .LSP_BASE(0), .F_BASE(F_BASE)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .odd_sel_i(odd_sel_i),
        .mem_in_i(mem_in_i), .mem_addr_o(mem_addr_o), .mem_write_o(mem_write_o),
        .mem_out_o(mem_out_o), .mpy_var1_o(mpy_var1_o), .mpy_var2_o(mpy_var2_o),
        .mpy_in_i(mpy_in_i), .overflow_o(overflow_o), .done_o(done_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [5:0][31:0] f;
        logic             ov;
        logic [31:0]      cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] last_f [0:5];
    logic [15:0] lsp_mem [0:9];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clock_i) cyc <= cyc + 1;

    // Scratch memory: one-cycle read latency, junk in the upper half-word.
    always @(posedge clock_i)
        mem_in_i <= (mem_addr_o < 12'd10) ? {16'hA5A5, lsp_mem[mem_addr_o[3:0]]} : 32'hDEAD_BEEF;

    function automatic bit oob(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    function automatic longint sat(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // mpy_32_16(hi, lo, n) = L_mac(L_mult(hi, n), mult(lo, n), 1)
    function automatic longint mpyl(input longint hi, input longint lo, input longint n);
        longint a, b;
        a = sat(hi * n * 2);
        b = (lo * n) >>> 15;
        if (b > 32767) b = 32767;
        if (b < -32768) b = -32768;
        return sat(a + b * 2);
    endfunction

    function automatic logic [31:0] mpy_stage(input logic [31:0] v1, input logic [15:0] v2);
        longint r;
        r = mpyl(longint'($signed(v1[31:16])), longint'($signed(v1[15:0])), longint'($signed(v2)));
        return r[31:0];
    endfunction

    assign mpy_in_i = mpy_stage(mpy_var1_o, mpy_var2_o);

    task automatic model(input bit odd, output exp_t e);
        longint f[6];
        longint l, x, t, hi, lo;
        bit     ov;
        ov   = 1'b0;
        f[0] = 64'sd16777216;
        l    = longint'($signed(lsp_mem[odd]));
        x    = -l * 1024;
        ov   |= oob(x);
        f[1] = sat(x);
        for (int i = 2; i <= 5; i++) begin
            l    = longint'($signed(lsp_mem[2 * (i - 1) + int'(odd)]));
            f[i] = f[i-2];
            for (int j = i; j >= 2; j--) begin
                hi   = f[j-1] >>> 16;
                lo   = (f[j-1] >>> 1) & 64'sh7FFF;
                t    = mpyl(hi, lo, l) * 2;
                ov   |= oob(t);
                t    = sat(t);
                x    = f[j] + f[j-2];
                ov   |= oob(x);
                x    = sat(x) - t;
                ov   |= oob(x);
                f[j] = sat(x);
            end
            x    = f[1] - l * 1024;
            ov   |= oob(x);
            f[1] = sat(x);
        end
        for (int n = 0; n < 6; n++) e.f[n] = f[n][31:0];
        e.ov  = ov;
        e.cyc = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: collects writes and settles each result against the scoreboard on done.
    always @(negedge clock_i) begin
        if (mem_write_o) begin
            wr_addr.push_back(32'(mem_addr_o));
            wr_data.push_back(mem_out_o);
        end
        if (done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("write_count", 64'(wr_addr.size()), 64'd6);
                for (int n = 0; n < 6 && n < wr_addr.size(); n++) begin
                    chk($sformatf("wr_addr[%0d]", n), 64'(wr_addr[n]), 64'(F_BASE + n));
                    chk($sformatf("f[%0d]", n), 64'(wr_data[n]), 64'(e.f[n]));
                    last_f[n] = wr_data[n];
                end
                chk("overflow", 64'(overflow_o), 64'(e.ov));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
            wr_addr.delete();
            wr_data.delete();
        end
    end

    // Called just after a negedge.
    task automatic run(input bit odd, input bit repulse);
        exp_t e;
        bit   got;
        model(odd, e);
        e.cyc = 32'(cyc + 31);
        sb.push_back(e);
        start_i   = 1'b1;
        odd_sel_i = odd;
        @(posedge clock_i);
        #1 start_i = 1'b0;
        if (repulse) begin
            repeat (10) @(negedge clock_i);
            start_i   = 1'b1;
            odd_sel_i = ~odd;
            @(negedge clock_i);
            start_i = 1'b0;
        end
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clock_i);
            got = done_o;
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clock_i);
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 10; i++) lsp_mem[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 7))
                0:       lsp_mem[i] = 16'h7FFF;
                1:       lsp_mem[i] = 16'h8000;
                default: lsp_mem[i] = 16'($urandom);
            endcase
        end
    endtask

    initial begin
        bit seen;
        fill(16'h0);
        for (int i = 0; i < 6; i++) last_f[i] = '0;
        repeat (3) @(negedge clock_i);
        chk("reset_outputs", {mem_addr_o, mem_write_o, mem_out_o, mpy_var2_o, overflow_o, done_o},
            64'd0);
        reset_i = 1'b1;
        @(negedge clock_i);
        chk("idle_outputs", {mem_addr_o, mem_write_o, mpy_var1_o, overflow_o, done_o}, 64'd0);

        run(1'b0, 1'b0);
        chk("t1_f2", 64'(last_f[2]), 64'h0500_0000);
        chk("t1_f4", 64'(last_f[4]), 64'h0A00_0000);

        fill(16'h0);
        lsp_mem[0] = 16'h4000;
        run(1'b0, 1'b0);
        chk("t2_f0", 64'(last_f[0]), 64'h0100_0000);
        chk("t2_f1", 64'(last_f[1]), 64'hFF00_0000);

        fill(16'h7FFF);
        run(1'b0, 1'b0);
        chk("t3_f1", 64'(last_f[1]), 64'hF600_1400);
        chk("t3_f4", 64'(last_f[4]), 64'h7FFF_FFFF);
        chk("t3_f5", 64'(last_f[5]), 64'h8000_0000);
        chk("t3_ovf", 64'(overflow_o), 64'd1);

        fill_random();
        run(1'b1, 1'b0);
        fill_random();
        run(1'b0, 1'b1);

        fill_random();
        lsp_mem[2] = 16'h1234;
        start_i    = 1'b1;
        odd_sel_i  = 1'b0;
        @(posedge clock_i);
        #1 start_i = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clock_i);
            seen = (mpy_var2_o != 16'h0);
        end
        chk("reached_loop", 64'(seen), 64'd1);
        reset_i = 1'b0;
        #1;
        chk("midrun_reset_outputs",
            {mem_addr_o, mem_write_o, mpy_var2_o, overflow_o, done_o, 16'(mem_out_o | mpy_var1_o)},
            64'd0);
        repeat (3) @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);
        run(1'b0, 1'b0);

        for (int r = 0; r < 1000; r++) begin
            fill_random();
            run(r[0], 1'b0);
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
